// File: rtl/rr_arbiter_n.sv
// N-way round-robin / fixed-priority arbiter with grant hold until eot,
// per-requester masking and a hold timeout that pre-empts a stalled owner.
module rr_arbiter_n #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] eot,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               prio_mode,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               timeout
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               to_q, to_d;

    logic [NUM_REQ-1:0] elig;
    logic [ID_W-1:0]    win;
    logic               win_ok;
    logic               own_eot;
    logic               own_req;
    logic               expired;
    logic               rel;

    assign elig    = req & ~mask;
    assign win_ok  = |elig;
    assign own_eot = eot[id_q];
    assign own_req = req[id_q];
    assign expired = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign rel     = own_eot | ~own_req | expired;

    // Loops run from the far end so the nearest match is assigned last.
    always_comb begin
        int j;
        win = ptr_q;
        j   = 0;
        if (prio_mode) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (elig[i]) win = ID_W'(i);
            end
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                j = (int'(ptr_q) + k) % NUM_REQ;
                if (elig[j]) win = ID_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_ok) begin
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << win;
                    id_d    = win;
                    ptr_d   = win;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    // Only a pure hold expiry counts as a forced release.
                    to_d = expired & ~own_eot & own_req;
                    if (win_ok) begin
                        gnt_d = NUM_REQ'(1) << win;
                        id_d  = win;
                        ptr_d = win;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (MAX_HOLD != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: vector table, directed timeout sequences,
// random traffic against a reference model, and an 8-way rotation.
module tb_rr_arbiter_n;

    logic       clk;
    logic       rst;
    logic [3:0] req, eot, mask;
    logic       prio;
    logic [3:0] gnt;
    logic       gv;
    logic [1:0] gid;
    logic       to;

    logic       rst8;
    logic [7:0] req8, eot8, mask8;
    logic       prio8;
    logic [7:0] gnt8;
    logic       gv8;
    logic [2:0] gid8;
    logic       to8;

    int n_chk = 0;
    int n_pass = 0;

    rr_arbiter_n #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst), .req(req), .eot(eot), .mask(mask),
        .prio_mode(prio), .gnt(gnt), .gnt_valid(gv), .gnt_id(gid),
        .timeout(to)
    );

    rr_arbiter_n #(.NUM_REQ(8), .MAX_HOLD(0)) dut8 (
        .clk(clk), .rst(rst8), .req(req8), .eot(eot8), .mask(mask8),
        .prio_mode(prio8), .gnt(gnt8), .gnt_valid(gv8), .gnt_id(gid8),
        .timeout(to8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] eot;
        logic [3:0] mask;
        logic       prio;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       to;
    } vec_t;

    vec_t tbl[20];

    // Reference model: owner index (-1 when idle), pointer, cycles held.
    int m_owner = -1;
    int m_ptr = 3;
    int m_cnt = 0;
    int m_id = 0;
    bit m_to = 0;

    function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] e,
                                logic [3:0] m, logic p, logic [3:0] g,
                                logic [1:0] id, logic t);
        vec_t v;
        v.rst = r; v.req = rq; v.eot = e; v.mask = m; v.prio = p;
        v.gnt = g; v.id = id; v.to = t;
        return v;
    endfunction

    function automatic int pick(logic [3:0] el, logic p, int base);
        if (p) begin
            for (int i = 0; i < 4; i++) if (el[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (el[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_step(logic r, logic [3:0] rq, logic [3:0] e,
                                       logic [3:0] m, logic p);
        int  w;
        bit  done, drop, exp_h;
        if (r) begin
            m_owner = -1; m_ptr = 3; m_cnt = 0; m_to = 0; m_id = 0;
            return;
        end
        m_to = 0;
        w = pick(rq & ~m, p, m_ptr);
        if (m_owner < 0) begin
            if (w >= 0) begin
                m_owner = w; m_ptr = w; m_id = w; m_cnt = 0;
            end
            return;
        end
        done  = e[m_owner];
        drop  = !rq[m_owner];
        exp_h = (m_cnt >= 15);
        if (done || drop || exp_h) begin
            m_to = exp_h && !done && !drop;
            if (w >= 0) begin
                m_owner = w; m_ptr = w; m_id = w; m_cnt = 0;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_cnt++;
        end
    endfunction

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s.%s got %0h want %0h", nm, fld, act, exp_v);
    endtask

    task automatic chk(input string nm, input logic [3:0] eg,
                       input logic [1:0] eid, input logic eto);
        cmp(nm, "gnt", 32'(gnt), 32'(eg));
        cmp(nm, "gnt_valid", 32'(gv), 32'(|eg));
        cmp(nm, "gnt_id", 32'(gid), 32'(eid));
        cmp(nm, "timeout", 32'(to), 32'(eto));
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] e,
                         input logic [3:0] m, input logic p);
        @(negedge clk);
        rst = r; req = rq; eot = e; mask = m; prio = p;
        model_step(r, rq, e, m, p);
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic r, input logic [7:0] rq, input logic [7:0] e);
        @(negedge clk);
        rst8 = r; req8 = rq; eot8 = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] e;
        logic [3:0] m;
        logic       p;
        logic       r;
        logic [7:0] oh;

        rst = 1'b1; req = '0; eot = '0; mask = '0; prio = 1'b0;
        rst8 = 1'b1; req8 = '0; eot8 = '0; mask8 = '0; prio8 = 1'b0;

        tbl[0]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
        tbl[1]  = mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0);
        tbl[2]  = mk(0, 4'b1111, 4'b0001, 4'b0000, 0, 4'b0010, 1, 0);
        tbl[3]  = mk(0, 4'b1111, 4'b0010, 4'b0000, 0, 4'b0100, 2, 0);
        tbl[4]  = mk(0, 4'b1111, 4'b0100, 4'b0000, 0, 4'b1000, 3, 0);
        tbl[5]  = mk(0, 4'b1111, 4'b1000, 4'b0000, 0, 4'b0001, 0, 0);
        tbl[6]  = mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0);
        tbl[7]  = mk(0, 4'b0101, 4'b0000, 4'b0001, 0, 4'b0100, 2, 0);
        tbl[8]  = mk(0, 4'b0101, 4'b0000, 4'b0000, 0, 4'b0100, 2, 0);
        tbl[9]  = mk(0, 4'b0101, 4'b0100, 4'b0000, 0, 4'b0001, 0, 0);
        tbl[10] = mk(0, 4'b0101, 4'b0100, 4'b0000, 0, 4'b0001, 0, 0);
        tbl[11] = mk(0, 4'b0101, 4'b0001, 4'b0000, 0, 4'b0100, 2, 0);
        tbl[12] = mk(0, 4'b1110, 4'b0100, 4'b0000, 1, 4'b0010, 1, 0);
        tbl[13] = mk(0, 4'b1110, 4'b0010, 4'b0000, 1, 4'b0010, 1, 0);
        tbl[14] = mk(0, 4'b1110, 4'b0010, 4'b0000, 1, 4'b0010, 1, 0);
        tbl[15] = mk(0, 4'b1110, 4'b0010, 4'b0000, 0, 4'b0100, 2, 0);
        tbl[16] = mk(1, 4'b1100, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
        tbl[17] = mk(0, 4'b1100, 4'b0000, 4'b0000, 0, 4'b0100, 2, 0);
        tbl[18] = mk(0, 4'b1100, 4'b0100, 4'b0000, 0, 4'b1000, 3, 0);
        tbl[19] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 3, 0);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].eot, tbl[i].mask, tbl[i].prio);
            chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].to);
        end

        // Stalled owner 1 with 3 waiting: 16 cycles, then forced handoff.
        for (int i = 0; i < 16; i++) begin
            drive(0, 4'b1010, 4'b0000, 4'b0000, 0);
            chk("hold1", 4'b0010, 1, 0);
        end
        drive(0, 4'b1010, 4'b0000, 4'b0000, 0);
        chk("to_hand", 4'b1000, 3, 1);
        drive(0, 4'b1010, 4'b0000, 4'b0000, 0);
        chk("to_pulse", 4'b1000, 3, 0);

        // Lone stalled requester is re-granted and timeout still pulses.
        drive(0, 4'b0010, 4'b1000, 4'b0000, 0);
        chk("lone_gnt", 4'b0010, 1, 0);
        for (int i = 0; i < 15; i++) begin
            drive(0, 4'b0010, 4'b0000, 4'b0000, 0);
            chk("lone_hold", 4'b0010, 1, 0);
        end
        drive(0, 4'b0010, 4'b0000, 4'b0000, 0);
        chk("lone_to", 4'b0010, 1, 1);
        drive(0, 4'b0010, 4'b0000, 4'b0000, 0);
        chk("lone_end", 4'b0010, 1, 0);

        // eot on the expiry cycle wins over timeout; foreign eot ignored.
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0);
        chk("drop", 4'b0000, 1, 0);
        drive(0, 4'b0011, 4'b0000, 4'b0000, 0);
        chk("own0", 4'b0001, 0, 0);
        for (int i = 0; i < 15; i++) begin
            drive(0, 4'b0011, 4'b0100, 4'b0000, 0);
            chk("foreign_eot", 4'b0001, 0, 0);
        end
        drive(0, 4'b0011, 4'b0001, 4'b0000, 0);
        chk("eot_vs_to", 4'b0010, 1, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0);
        chk("idle", 4'b0000, 1, 0);

        // Random traffic against the model.
        drive(1, 4'b0000, 4'b0000, 4'b0000, 0);
        chk("rand_rst", 4'b0000, 0, 0);
        rq = '0;
        p = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_owner == i) begin
                    if ($urandom_range(31) == 0) rq[i] = 1'b0;
                end else if (rq[i]) begin
                    if ($urandom_range(15) == 0) rq[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    rq[i] = 1'b1;
                end
                e[i] = ($urandom_range(11) == 0);
                m[i] = ($urandom_range(7) == 0);
            end
            if ($urandom_range(19) == 0) p = ~p;
            r = ($urandom_range(299) == 0);
            drive(r, rq, e, m, p);
            chk("rand", (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner),
                2'(m_id), m_to);
        end

        // 8-way rotation with wrap, then indefinite hold (no timeout).
        drive(1, 4'b0000, 4'b0000, 4'b0000, 0);
        drive8(1, 8'h00, 8'h00);
        cmp("r8_rst", "gnt", 32'(gnt8), 32'h0);
        drive8(0, 8'hFF, 8'h00);
        cmp("r8_first", "gnt", 32'(gnt8), 32'h01);
        for (int j = 1; j <= 8; j++) begin
            oh = 8'(1 << ((j - 1) % 8));
            drive8(0, 8'hFF, oh);
            cmp($sformatf("r8_%0d", j), "gnt", 32'(gnt8), 32'(1 << (j % 8)));
            cmp($sformatf("r8_%0d", j), "gnt_id", 32'(gid8), 32'(j % 8));
        end
        for (int j = 0; j < 40; j++) begin
            drive8(0, 8'hFF, 8'h00);
            cmp("r8_hold", "timeout", 32'(to8), 32'h0);
        end
        cmp("r8_hold", "gnt", 32'(gnt8), 32'h01);
        cmp("r8_hold", "gnt_valid", 32'(gv8), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
